// File: rtl/alu_op_decode_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decode_fifo
// Purpose  : Multi-lane ALU-operation decoder feeding an in-order buffer that
//            sits between rename/dispatch and ALU issue. Up to LANES
//            instructions are decoded per cycle and enqueued all-or-nothing,
//            with invalid lanes compressed out. The head entry is presented
//            first-word-fall-through on a valid/ready handshake.
// Ports    : clk         - clock, rising edge
//            rst_n       - asynchronous active-low reset
//            flush       - synchronous flush of all buffered entries
//            in_valid    - per-lane valid            [LANES]
//            in_insn     - per-lane raw instruction  [LANES*32], lane l at l*32
//            in_alu_op   - per-lane control alu_op   [LANES*2],  lane l at l*2
//            in_ready    - group can be accepted this cycle
//            out_valid   - head entry valid
//            out_ready   - issue stage consumes head
//            out_op      - decoded ALU operation of head (31 when empty)
//            out_insn    - instruction of head (0 when empty)
//            out_illegal - head entry failed decode (0 when empty)
//            count       - occupied entries
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_decode_fifo #(
  parameter int LANES    = 2,
  parameter int DEPTH    = 8,
  parameter int ENABLE_M = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*32-1:0]          in_insn,
  input  logic [LANES*2-1:0]           in_alu_op,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4:0]                   out_op,
  output logic [31:0]                  out_insn,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // ALU operation encoding
  localparam logic [4:0] c_op_add   = 5'd0;
  localparam logic [4:0] c_op_sub   = 5'd1;
  localparam logic [4:0] c_op_xor   = 5'd2;
  localparam logic [4:0] c_op_or    = 5'd3;
  localparam logic [4:0] c_op_and   = 5'd4;
  localparam logic [4:0] c_op_sll   = 5'd5;
  localparam logic [4:0] c_op_srl   = 5'd6;
  localparam logic [4:0] c_op_sra   = 5'd7;
  localparam logic [4:0] c_op_slt   = 5'd8;
  localparam logic [4:0] c_op_sltu  = 5'd9;
  localparam logic [4:0] c_op_lui   = 5'd10;
  localparam logic [4:0] c_op_auipc = 5'd11;
  localparam logic [4:0] c_op_mul   = 5'd12;
  localparam logic [4:0] c_op_nop   = 5'd31;

  // Major opcodes
  localparam logic [6:0] c_opc_rtype  = 7'b0110011;
  localparam logic [6:0] c_opc_itype  = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;

  localparam logic [6:0] c_f7_base = 7'h00;
  localparam logic [6:0] c_f7_alt  = 7'h20;
  localparam logic [6:0] c_f7_mext = 7'h01;

  // Base integer operation selected by funct3 (shared by R-type and I-type)
  function automatic logic [4:0] f_base_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'd0:    op = c_op_add;
      3'd1:    op = c_op_sll;
      3'd2:    op = c_op_slt;
      3'd3:    op = c_op_sltu;
      3'd4:    op = c_op_xor;
      3'd5:    op = c_op_srl;
      3'd6:    op = c_op_or;
      default: op = c_op_and;
    endcase
    return op;
  endfunction

  // Returns {illegal, op}. Illegal encodings always carry the no-op code.
  function automatic logic [5:0] f_decode(
    input logic [6:0] opc,
    input logic [2:0] f3,
    input logic [6:0] f7,
    input logic [1:0] alu_op
  );
    logic [4:0] op;
    logic       ill;
    op  = c_op_nop;
    ill = 1'b0;
    case (alu_op)
      2'b00: op = c_op_add;
      2'b01: op = c_op_sub;
      2'b11: op = c_op_nop;
      default: begin
        case (opc)
          c_opc_rtype: begin
            if (f7 == c_f7_base)                    op = f_base_op(f3);
            else if (f7 == c_f7_alt && f3 == 3'd0)  op = c_op_sub;
            else if (f7 == c_f7_alt && f3 == 3'd5)  op = c_op_sra;
            else if (f7 == c_f7_mext && ENABLE_M != 0)
              op = c_op_mul + {2'b00, f3};
            else                                    ill = 1'b1;
          end
          c_opc_itype: begin
            case (f3)
              3'd1: begin
                if (f7 == c_f7_base) op = c_op_sll;
                else                 ill = 1'b1;
              end
              3'd5: begin
                if (f7 == c_f7_base)     op = c_op_srl;
                else if (f7 == c_f7_alt) op = c_op_sra;
                else                     ill = 1'b1;
              end
              // funct7 is immediate data for the non-shift forms
              default: op = f_base_op(f3);
            endcase
          end
          c_opc_load, c_opc_store, c_opc_jalr, c_opc_jal: op = c_op_add;
          c_opc_branch: op = c_op_sub;
          c_opc_lui:    op = c_op_lui;
          c_opc_auipc:  op = c_op_auipc;
          default:      ill = 1'b1;
        endcase
      end
    endcase
    if (ill) op = c_op_nop;
    return {ill, op};
  endfunction

  // Storage
  logic [4:0]    r_mem_op   [DEPTH];
  logic [31:0]   r_mem_insn [DEPTH];
  logic          r_mem_ill  [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [5:0]    w_dec  [LANES];
  logic [PW-1:0] w_off  [LANES];
  logic [PW-1:0] w_slot [LANES];
  logic [CW-1:0] w_pop;
  logic          w_enq;
  logic          w_deq;
  logic [CW-1:0] w_add;
  logic [CW-1:0] w_sub;

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_dec[l] = f_decode(in_insn[l*32 +: 7],
                                 in_insn[l*32+12 +: 3],
                                 in_insn[l*32+25 +: 7],
                                 in_alu_op[l*2 +: 2]);
      assign w_slot[l] = r_wr_ptr + w_off[l];
    end
  endgenerate

  // Each valid lane's slot offset is the number of valid lanes below it,
  // which packs the accepted group into consecutive slots.
  always_comb begin
    w_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      w_off[l] = w_pop[PW-1:0];
      if (in_valid[l]) w_pop = w_pop + CW'(1);
    end
  end

  // Readiness is based on registered occupancy only, so a concurrent pop
  // never admits a group that could overflow.
  assign in_ready  = (CW'(DEPTH) - r_count) >= CW'(LANES);
  assign out_valid = (r_count != '0);
  assign w_enq     = in_ready && (|in_valid) && !flush;
  assign w_deq     = out_valid && out_ready && !flush;
  assign w_add     = w_enq ? w_pop : '0;
  assign w_sub     = CW'(w_deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(w_pop);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + w_add - w_sub;
    end
  end

  // Array contents need no reset: occupancy alone qualifies every read.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int l = 0; l < LANES; l++) begin
        if (in_valid[l]) begin
          r_mem_op[w_slot[l]]   <= w_dec[l][4:0];
          r_mem_ill[w_slot[l]]  <= w_dec[l][5];
          r_mem_insn[w_slot[l]] <= in_insn[l*32 +: 32];
        end
      end
    end
  end

  assign out_op      = out_valid ? r_mem_op[r_rd_ptr]   : c_op_nop;
  assign out_insn    = out_valid ? r_mem_insn[r_rd_ptr] : 32'd0;
  assign out_illegal = out_valid ? r_mem_ill[r_rd_ptr]  : 1'b0;
  assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_decode_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_decode_fifo
// Purpose  : Bench for alu_op_decode_fifo. Two instances (RV32M enabled and
//            disabled) share one stimulus; an entry queue plus a reference
//            decoder predicts every observable output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_decode_fifo;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic [LANES-1:0]    in_valid;
  logic [LANES*32-1:0] in_insn;
  logic [LANES*2-1:0]  in_alu_op;
  logic                out_ready;

  logic          rdy_o   [2];
  logic          vld_o   [2];
  logic [4:0]    op_o    [2];
  logic [31:0]   insn_o  [2];
  logic          ill_o   [2];
  logic [CW-1:0] cnt_o   [2];

  always #5 clk = ~clk;

  alu_op_decode_fifo #(.LANES(LANES), .DEPTH(DEPTH), .ENABLE_M(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_insn(in_insn), .in_alu_op(in_alu_op),
    .in_ready(rdy_o[0]), .out_valid(vld_o[0]), .out_ready(out_ready),
    .out_op(op_o[0]), .out_insn(insn_o[0]), .out_illegal(ill_o[0]),
    .count(cnt_o[0])
  );

  alu_op_decode_fifo #(.LANES(LANES), .DEPTH(DEPTH), .ENABLE_M(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_insn(in_insn), .in_alu_op(in_alu_op),
    .in_ready(rdy_o[1]), .out_valid(vld_o[1]), .out_ready(out_ready),
    .out_op(op_o[1]), .out_insn(insn_o[1]), .out_illegal(ill_o[1]),
    .count(cnt_o[1])
  );

  typedef struct {
    logic [31:0] insn;
    logic [1:0]  aop;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   base_tbl [8] = '{0, 5, 8, 9, 2, 6, 3, 4};

  // Reference decode, returns {illegal, op}
  function automatic logic [5:0] ref_decode(logic [31:0] insn, logic [1:0] aop, bit m);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] bad;
    logic [5:0] base;
    opc  = insn[6:0];
    f3   = insn[14:12];
    f7   = insn[31:25];
    bad  = {1'b1, 5'd31};
    base = {1'b0, 5'(base_tbl[f3])};
    if (aop == 2'b00) return 6'd0;
    if (aop == 2'b01) return 6'd1;
    if (aop == 2'b11) return 6'd31;
    case (opc)
      7'h33: begin
        if (f7 == 7'h00) return base;
        if (f7 == 7'h20 && f3 == 3'd0) return 6'd1;
        if (f7 == 7'h20 && f3 == 3'd5) return 6'd7;
        if (f7 == 7'h01 && m) return 6'(12 + int'(f3));
        return bad;
      end
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? base : bad;
        if (f3 == 3'd5) begin
          if (f7 == 7'h00) return 6'd6;
          if (f7 == 7'h20) return 6'd7;
          return bad;
        end
        return base;
      end
      7'h03, 7'h23, 7'h67, 7'h6F: return 6'd0;
      7'h63: return 6'd1;
      7'h37: return 6'd10;
      7'h17: return 6'd11;
      default: return bad;
    endcase
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] x;
    logic [6:0]  f7;
    x = $urandom();
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = 7'($urandom());
    endcase
    case ($urandom_range(0, 7))
      0, 1, 2: begin x[6:0] = 7'h33; x[31:25] = f7; end
      3, 4:    begin x[6:0] = 7'h13; x[31:25] = f7; end
      5: begin
        case ($urandom_range(0, 6))
          0: x[6:0] = 7'h03;
          1: x[6:0] = 7'h23;
          2: x[6:0] = 7'h63;
          3: x[6:0] = 7'h67;
          4: x[6:0] = 7'h6F;
          5: x[6:0] = 7'h37;
          default: x[6:0] = 7'h17;
        endcase
      end
      default: ;
    endcase
    return x;
  endfunction

  function automatic logic [1:0] rand_aop();
    case ($urandom_range(0, 9))
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [5:0] d;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d_count", m), 32'(cnt_o[m]), 32'(q.size()));
      chk($sformatf("m%0d_in_ready", m), 32'(rdy_o[m]), 32'((DEPTH - q.size()) >= LANES));
      chk($sformatf("m%0d_out_valid", m), 32'(vld_o[m]), 32'(q.size() != 0));
      if (q.size() != 0) begin
        d = ref_decode(q[0].insn, q[0].aop, m[0]);
        chk($sformatf("m%0d_out_op", m), 32'(op_o[m]), 32'(d[4:0]));
        chk($sformatf("m%0d_out_illegal", m), 32'(ill_o[m]), 32'(d[5]));
        chk($sformatf("m%0d_out_insn", m), insn_o[m], q[0].insn);
      end else begin
        chk($sformatf("m%0d_out_op_empty", m), 32'(op_o[m]), 32'd31);
        chk($sformatf("m%0d_out_illegal_empty", m), 32'(ill_o[m]), 32'd0);
        chk($sformatf("m%0d_out_insn_empty", m), insn_o[m], 32'd0);
      end
    end
  endtask

  // One clock: predict acceptance from the model, advance, update, check.
  task automatic cycle();
    bit acc;
    bit deq;
    acc = ((DEPTH - q.size()) >= LANES) && (in_valid != '0) && !flush;
    deq = (q.size() != 0) && out_ready && !flush;
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (deq) void'(q.pop_front());
      if (acc) begin
        for (int l = 0; l < LANES; l++) begin
          if (in_valid[l]) q.push_back('{in_insn[l*32 +: 32], in_alu_op[l*2 +: 2]});
        end
      end
    end
    check_state();
  endtask

  task automatic drive(logic [1:0] v, logic [31:0] i0, logic [1:0] a0,
                       logic [31:0] i1, logic [1:0] a1);
    in_valid  = v;
    in_insn   = {i1, i0};
    in_alu_op = {a1, a0};
  endtask

  task automatic drive_rand(logic [1:0] v);
    drive(v, rand_insn(), rand_aop(), rand_insn(), rand_aop());
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(2'b00, 32'd0, 2'b00, 32'd0, 2'b00);

    // Reset values while held in reset
    #2;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single sub on lane 0
    drive(2'b01, 32'h40B50533, 2'b10, 32'd0, 2'b00);
    cycle();
    drive(2'b00, 32'd0, 2'b00, 32'd0, 2'b00);
    out_ready = 1'b1;
    cycle();

    // mul + div pair, then drain in order
    out_ready = 1'b0;
    drive(2'b11, 32'h027302B3, 2'b10, 32'h027342B3, 2'b10);
    cycle();
    drive(2'b00, 32'd0, 2'b00, 32'd0, 2'b00);
    out_ready = 1'b1;
    cycle();
    cycle();

    // Compression: only lane 1 valid
    out_ready = 1'b0;
    drive(2'b10, 32'hFFFFFFFF, 2'b10, 32'h12345537, 2'b10);
    cycle();
    drive(2'b00, 32'd0, 2'b00, 32'd0, 2'b00);
    out_ready = 1'b1;
    cycle();

    // Fill to 7 with output stalled; in_ready must drop there
    out_ready = 1'b0;
    drive_rand(2'b01);
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive_rand(2'b11);
      cycle();
    end
    // Drain one to 6, then enqueue two while dequeuing one -> 7
    drive(2'b00, 32'd0, 2'b00, 32'd0, 2'b00);
    out_ready = 1'b1;
    cycle();
    drive_rand(2'b11);
    cycle();

    // Random traffic, many wrap-arounds
    for (int k = 0; k < 300; k++) begin
      drive_rand(2'($urandom_range(0, 3)));
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // Drain, fill 5, then flush with both handshakes active
    drive(2'b00, 32'd0, 2'b00, 32'd0, 2'b00);
    out_ready = 1'b1;
    for (int k = 0; k < 2 * DEPTH && q.size() != 0; k++) cycle();
    chk("drained", 32'(cnt_o[1]), 32'd0);
    out_ready = 1'b0;
    drive_rand(2'b11);
    cycle();
    drive_rand(2'b11);
    cycle();
    drive_rand(2'b01);
    cycle();
    flush     = 1'b1;
    out_ready = 1'b1;
    drive_rand(2'b11);
    cycle();
    flush     = 1'b0;
    drive(2'b00, 32'd0, 2'b00, 32'd0, 2'b00);
    cycle();

    // Fill 4, then assert reset between edges
    out_ready = 1'b0;
    drive_rand(2'b11);
    cycle();
    drive_rand(2'b11);
    cycle();
    drive(2'b00, 32'd0, 2'b00, 32'd0, 2'b00);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
